stream_mux_rr: RTL
==================

Name: stream_mux_rr

Overview:
- Parametrised N-to-1 stream selector; successor to the 4:1 combinational selector.
- Arbitrates N valid/ready input channels onto one registered output channel.
- Two modes, chosen at run time: fixed select by index (classic mux behaviour), or fair round-robin.
- Sits between producer lanes and a single consumer, e.g. a shared bus or output port in the learning SoC.

Parameters:
- NR_CH, 4, number of input channels (2..16; need not be a power of two)
- SEL_W, 2, width of the select index; must satisfy 2**SEL_W >= NR_CH
- DW, 8, data width per channel

Ports:
- clk  input  1  single clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- mode  input  1  0 = fixed select via s; 1 = round-robin
- s  input  SEL_W  channel index used in fixed mode
- in_valid  input  NR_CH  per-channel valid; bit i = channel i
- in_data  input  NR_CH*DW  packed data; channel i = in_data[i*DW +: DW]
- in_ready  output  NR_CH  per-channel ready (combinational)
- out_valid  output  1  output holds a word (registered)
- out_data  output  DW  output word (registered)
- out_ch  output  SEL_W  source channel of the current out_data (registered)
- out_ready  input  1  consumer accepts the word

Behaviour:
- Reset (rst=1 at an edge): out_valid=0, out_data=0, out_ch=0, internal pointer rr_ptr=0. Reset applied mid-transfer discards any held word. in_ready is all zero while rst=1.
- load = !out_valid || out_ready. The output register may capture only when load=1.
- Fixed mode (mode=0):
  - g = s.
  - If s < NR_CH: in_ready[g] = load and every other in_ready bit = 0.
  - If s >= NR_CH: no grant and in_ready = 0 (equivalent to the old default of 0).
- Round-robin mode (mode=1):
  - Scan channels rr_ptr, rr_ptr+1, ..., wrapping modulo NR_CH; g = first channel with in_valid set.
  - in_ready[g] = load; every other bit = 0.
  - If no channel is valid, in_ready = 0.
- Transfer: in_valid[g] && in_ready[g] at an edge. The next state is then out_valid=1, out_data=in_data[g], out_ch=g.
- On a transfer in round-robin mode, rr_ptr <= (g==NR_CH-1) ? 0 : g+1. rr_ptr is unchanged in fixed mode and on cycles with no transfer.
- Output handshake:
  - out_valid && out_ready with no new transfer -> out_valid <= 0. out_data and out_ch keep their last value.
  - out_valid && !out_ready -> out_valid, out_data and out_ch are held stable (AXI-style; no data change while stalled).
  - Simultaneous drain and new transfer in one cycle is legal, giving back-to-back throughput of 1 word/cycle.
- Latency: 1 cycle from input handshake to out_valid.
- in_ready depends on in_valid only in round-robin mode. It never depends on in_data.
- Mode or s may change on any cycle. A change affects only the next grant; a word already held in the output is unaffected.
- A channel whose valid is not granted must hold its data (standard valid/ready rule). The block does not check this.
- A non-power-of-two NR_CH (e.g. 3 with SEL_W=2) must wrap correctly: the pointer never reaches 3.

Test Plan:
- Reset/idle: assert rst for 2 cycles with all in_valid=1 -> out_valid=0, out_data=0, out_ch=0, in_ready=0 during reset.
- Fixed mode: mode=0, s=2, in_valid=4'b1111, ch2 presents 0xA5, out_ready=1.
  - Expect in_ready=4'b0100 and next cycle out_valid=1, out_data=0xA5, out_ch=2.
  - Then set s=3 -> ch3 data on the following cycle.
- Round-robin fairness: mode=1, in_valid=4'b1111 constant, channel i presents 0x10+i, out_ready=1.
  - out_ch sequence 0,1,2,3,0,1 on consecutive cycles.
  - in_ready one-hot and rotating.
- Sparse/wrap: mode=1, only ch3 and ch1 valid, rr_ptr=2.
  - Grant order 3,1,3,1.
  - With NR_CH=3 and all channels valid, order 0,1,2,0 (no out-of-range index).
- Backpressure: deliver ch1=0x5C, then hold out_ready=0 for 3 cycles.
  - out_valid=1, out_data=0x5C and out_ch=1 stay stable.
  - in_ready=0 during the stall.
  - When out_ready rises, the next granted word appears the following cycle with no bubble.
- Reset mid-operation: out_valid=1 stalled and rr_ptr=3; pulse rst.
  - Next cycle out_valid=0.
  - The first round-robin grant after reset goes to ch0 when all channels are valid.

Source files
------------

// File: rtl/stream_mux_rr_if.sv
// Stream selector channel bundle: N input lanes plus one registered output lane.
// The slave modport is the selector's view; the master modport drives it.
interface stream_mux_rr_if #(
    parameter int NR_CH = 4,
    parameter int SEL_W = 2,
    parameter int DW    = 8
);
    logic                  mode;
    logic [SEL_W-1:0]      s;
    logic [NR_CH-1:0]      in_valid;
    logic [NR_CH*DW-1:0]   in_data;
    logic [NR_CH-1:0]      in_ready;
    logic                  out_valid;
    logic [DW-1:0]         out_data;
    logic [SEL_W-1:0]      out_ch;
    logic                  out_ready;

    modport master (
        output mode, s, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_ch
    );

    modport slave (
        input  mode, s, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_ch
    );
endinterface

// File: rtl/stream_mux_rr.sv
// N-to-1 valid/ready stream selector with a registered output stage.
// Grants either the channel indexed by s (mode=0) or round-robin from rr_ptr (mode=1).
module stream_mux_rr #(
    parameter int NR_CH = 4,
    parameter int SEL_W = 2,
    parameter int DW    = 8
) (
    input  logic            clk,
    input  logic            rst,
    stream_mux_rr_if.slave  bus
);

    logic [SEL_W-1:0] rr_ptr;
    logic             out_valid_q;
    logic [DW-1:0]    out_data_q;
    logic [SEL_W-1:0] out_ch_q;

    logic             load;
    logic [SEL_W-1:0] g;
    logic             g_ok;
    logic [NR_CH-1:0] ready_c;
    logic             xfer;
    logic [DW-1:0]    data_sel;
    logic [SEL_W-1:0] ptr_nxt;
    int               t;

    always_comb begin
        load     = !out_valid_q || bus.out_ready;
        g        = '0;
        g_ok     = 1'b0;
        t        = 0;
        ready_c  = '0;
        xfer     = 1'b0;
        data_sel = '0;

        if (!bus.mode) begin
            g    = bus.s;
            g_ok = (int'(bus.s) < NR_CH);
        end else begin
            // Scan offsets 0..NR_CH-1 from the pointer; the first valid channel wins.
            for (int k = 0; k < NR_CH; k++) begin
                t = int'(rr_ptr) + k;
                if (t >= NR_CH) t = t - NR_CH;
                for (int c = 0; c < NR_CH; c++) begin
                    if (!g_ok && c == t && bus.in_valid[c]) begin
                        g    = SEL_W'(c);
                        g_ok = 1'b1;
                    end
                end
            end
        end

        for (int c = 0; c < NR_CH; c++) begin
            if (g_ok && SEL_W'(c) == g) begin
                ready_c[c] = load && !rst;
                xfer       = load && !rst && bus.in_valid[c];
                data_sel   = bus.in_data[c*DW +: DW];
            end
        end

        // Explicit wrap keeps the pointer inside 0..NR_CH-1 for non-power-of-two NR_CH.
        ptr_nxt = (int'(g) == NR_CH - 1) ? '0 : g + SEL_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            rr_ptr      <= '0;
        end else begin
            if (xfer) begin
                out_valid_q <= 1'b1;
                out_data_q  <= data_sel;
                out_ch_q    <= g;
                if (bus.mode) rr_ptr <= ptr_nxt;
            end else if (bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign bus.in_ready  = ready_c;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_ch    = out_ch_q;

endmodule
